// File: rtl/imem_arbiter_pkg.sv
// Shared encodings and sizing helpers for the instruction-SRAM arbiter.
package udlx_imem_pkg;

  typedef enum logic [1:0] {
    IMEM_IDLE   = 2'd0,
    IMEM_ACCESS = 2'd1,
    IMEM_RESP   = 2'd2
  } imem_state_t;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_LDR   = 1'b1
  } imem_owner_t;

  // Wide enough for LDR_MAX_BURST up to 15.
  localparam int unsigned STARVE_W = 4;

  function automatic int unsigned wait_cnt_width(input int unsigned wait_states);
    int unsigned w;
    w = $clog2(wait_states + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Requester and SRAM pin bundle; slave is the arbiter side, master the fetch/loader/SRAM side.
interface imem_arbiter_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32
);
  logic                  fetch_req_in;
  logic [ADDR_WIDTH-1:0] fetch_addr_in;
  logic                  fetch_gnt_out;
  logic [DATA_WIDTH-1:0] fetch_data_out;
  logic                  fetch_stall_out;
  logic                  ldr_req_in;
  logic                  ldr_we_in;
  logic [ADDR_WIDTH-1:0] ldr_addr_in;
  logic [DATA_WIDTH-1:0] ldr_wdata_in;
  logic                  ldr_gnt_out;
  logic [DATA_WIDTH-1:0] ldr_rdata_out;
  logic                  mem_cs_out;
  logic                  mem_we_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [DATA_WIDTH-1:0] mem_wdata_out;
  logic [DATA_WIDTH-1:0] mem_data_in;

  modport slave (
    input  fetch_req_in, fetch_addr_in, ldr_req_in, ldr_we_in, ldr_addr_in,
           ldr_wdata_in, mem_data_in,
    output fetch_gnt_out, fetch_data_out, fetch_stall_out, ldr_gnt_out,
           ldr_rdata_out, mem_cs_out, mem_we_out, mem_addr_out, mem_wdata_out
  );

  modport master (
    output fetch_req_in, fetch_addr_in, ldr_req_in, ldr_we_in, ldr_addr_in,
           ldr_wdata_in, mem_data_in,
    input  fetch_gnt_out, fetch_data_out, fetch_stall_out, ldr_gnt_out,
           ldr_rdata_out, mem_cs_out, mem_we_out, mem_addr_out, mem_wdata_out
  );
endinterface

// File: rtl/imem_arbiter_wait_counter.sv
// Loadable down-counter for SRAM wait states; zero flag is combinational from the count.
module imem_wait_counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction SRAM sequencer shared by fetch and loader; grant MEM_WAIT_STATES+2 cycles
// after arbitration, requesters hold their request until the one-cycle gnt, fetch stalled meanwhile.
module imem_arbiter #(
  parameter int ADDR_WIDTH      = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_WAIT_STATES = 1,
  parameter int LDR_MAX_BURST   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  imem_arbiter_if.slave   bus
);
  import udlx_imem_pkg::*;

  localparam int unsigned CNT_W = wait_cnt_width(MEM_WAIT_STATES);

  imem_state_t           state;
  imem_owner_t           owner;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  cs_q;
  logic                  we_q;
  logic                  fetch_gnt_q;
  logic                  ldr_gnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] fetch_data_q;
  logic [DATA_WIDTH-1:0] ldr_rdata_q;
  logic                  fetch_starved;
  logic                  ldr_win;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_zero;

  // Loader has priority unless it has already taken LDR_MAX_BURST grants past a waiting fetch.
  always_comb begin
    fetch_starved = bus.fetch_req_in && (starve_cnt == STARVE_W'(LDR_MAX_BURST));
    ldr_win       = bus.ldr_req_in && !fetch_starved;
    cnt_load      = (state == IMEM_IDLE) && (bus.fetch_req_in || bus.ldr_req_in);
    cnt_dec       = (state == IMEM_ACCESS) && !cnt_zero;
  end

  imem_wait_counter #(.WIDTH(CNT_W)) u_wait (
    .clk      (clk),
    .rst      (rst_n),
    .load     (cnt_load),
    .load_val (CNT_W'(MEM_WAIT_STATES)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= IMEM_IDLE;
      owner        <= OWNER_FETCH;
      starve_cnt   <= '0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      fetch_gnt_q  <= 1'b0;
      ldr_gnt_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      fetch_data_q <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      case (state)
        IMEM_IDLE: begin
          if (ldr_win) begin
            owner      <= OWNER_LDR;
            cs_q       <= 1'b1;
            we_q       <= bus.ldr_we_in;
            addr_q     <= bus.ldr_addr_in;
            wdata_q    <= bus.ldr_wdata_in;
            starve_cnt <= bus.fetch_req_in ? starve_cnt + 1'b1 : '0;
            state      <= IMEM_ACCESS;
          end else if (bus.fetch_req_in) begin
            owner      <= OWNER_FETCH;
            cs_q       <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= bus.fetch_addr_in;
            wdata_q    <= '0;
            starve_cnt <= '0;
            state      <= IMEM_ACCESS;
          end else begin
            starve_cnt <= '0;
          end
        end
        IMEM_ACCESS: begin
          if (cnt_zero) begin
            if (owner == OWNER_FETCH) begin
              fetch_data_q <= bus.mem_data_in;
            end else if (!we_q) begin
              ldr_rdata_q <= bus.mem_data_in;
            end
            fetch_gnt_q <= (owner == OWNER_FETCH);
            ldr_gnt_q   <= (owner == OWNER_LDR);
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            state       <= IMEM_RESP;
          end
        end
        IMEM_RESP: begin
          fetch_gnt_q <= 1'b0;
          ldr_gnt_q   <= 1'b0;
          state       <= IMEM_IDLE;
        end
        default: begin
          state <= IMEM_IDLE;
        end
      endcase
    end
  end

  assign bus.fetch_gnt_out   = fetch_gnt_q;
  assign bus.fetch_data_out  = fetch_data_q;
  assign bus.fetch_stall_out = bus.fetch_req_in && !fetch_gnt_q;
  assign bus.ldr_gnt_out     = ldr_gnt_q;
  assign bus.ldr_rdata_out   = ldr_rdata_q;
  assign bus.mem_cs_out      = cs_q;
  assign bus.mem_we_out      = we_q;
  assign bus.mem_addr_out    = addr_q;
  assign bus.mem_wdata_out   = wdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: three instances with 1, 3 and 0 wait states.
module tb_imem_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  imem_arbiter_if #(.ADDR_WIDTH(20), .DATA_WIDTH(32)) b1 ();
  imem_arbiter_if #(.ADDR_WIDTH(20), .DATA_WIDTH(32)) b3 ();
  imem_arbiter_if #(.ADDR_WIDTH(20), .DATA_WIDTH(32)) b0 ();

  imem_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .MEM_WAIT_STATES(1), .LDR_MAX_BURST(4))
    dut1 (.clk(clk), .rst_n(rst), .bus(b1));
  imem_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .MEM_WAIT_STATES(3), .LDR_MAX_BURST(4))
    dut3 (.clk(clk), .rst_n(rst), .bus(b3));
  imem_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .MEM_WAIT_STATES(0), .LDR_MAX_BURST(4))
    dut0 (.clk(clk), .rst_n(rst), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b1.fetch_req_in = 1'b1; b1.fetch_addr_in = 20'h00066;
    b1.ldr_req_in = 1'b1; b1.ldr_we_in = 1'b0; b1.ldr_addr_in = 20'h00055;
    b1.ldr_wdata_in = 32'h0; b1.mem_data_in = 32'hA5A5A5A5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (b1.mem_cs_out !== 1'b0 || b1.mem_we_out !== 1'b0 || b1.mem_addr_out !== 20'h0 || b1.mem_wdata_out !== 32'h0) begin
        bad++;
        $display("FAIL reset_mem cyc=%0d cs=%b we=%b addr=%h wdata=%h expected all zero",
                 c, b1.mem_cs_out, b1.mem_we_out, b1.mem_addr_out, b1.mem_wdata_out);
      end
      total++;
      if (b1.fetch_gnt_out !== 1'b0 || b1.ldr_gnt_out !== 1'b0 || b1.fetch_data_out !== 32'h0 || b1.ldr_rdata_out !== 32'h0) begin
        bad++;
        $display("FAIL reset_resp cyc=%0d fgnt=%b lgnt=%b fdata=%h lrdata=%h expected all zero",
                 c, b1.fetch_gnt_out, b1.ldr_gnt_out, b1.fetch_data_out, b1.ldr_rdata_out);
      end
      total++;
      if (b1.fetch_stall_out !== 1'b1) begin
        bad++;
        $display("FAIL reset_stall cyc=%0d got=%b expected 1", c, b1.fetch_stall_out);
      end
      next_cycle();
    end
    rst = 1'b0;
    // Loader wins the first arbitration after release.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (b1.mem_cs_out !== (c == 1 || c == 2)) begin
        bad++;
        $display("FAIL post_reset_cs cyc=%0d got=%b expected %b", c, b1.mem_cs_out, (c == 1 || c == 2));
      end
      if (c == 1) begin
        total++;
        if (b1.mem_addr_out !== 20'h00055) begin
          bad++;
          $display("FAIL post_reset_addr got=%h expected 00055", b1.mem_addr_out);
        end
      end
      if (c == 3) begin
        total++;
        if (b1.ldr_gnt_out !== 1'b1 || b1.fetch_gnt_out !== 1'b0 || b1.ldr_rdata_out !== 32'hA5A5A5A5) begin
          bad++;
          $display("FAIL post_reset_gnt lgnt=%b fgnt=%b lrdata=%h expected 1 0 a5a5a5a5",
                   b1.ldr_gnt_out, b1.fetch_gnt_out, b1.ldr_rdata_out);
        end
      end
      next_cycle();
    end
    b1.fetch_req_in = 1'b0; b1.ldr_req_in = 1'b0;
    next_cycle();
  endtask

  task automatic test_fetch_read();
    b1.fetch_req_in = 1'b1; b1.fetch_addr_in = 20'h00010; b1.mem_data_in = 32'hDEADBEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (b1.mem_cs_out !== (c == 1 || c == 2) || b1.fetch_gnt_out !== (c == 3) || b1.fetch_stall_out !== (c != 3)) begin
        bad++;
        $display("FAIL fetch_seq cyc=%0d cs=%b gnt=%b stall=%b expected %b %b %b", c,
                 b1.mem_cs_out, b1.fetch_gnt_out, b1.fetch_stall_out, (c == 1 || c == 2), (c == 3), (c != 3));
      end
      if (c == 1) begin
        total++;
        if (b1.mem_addr_out !== 20'h00010 || b1.mem_we_out !== 1'b0) begin
          bad++;
          $display("FAIL fetch_addr got=%h we=%b expected 00010 0", b1.mem_addr_out, b1.mem_we_out);
        end
      end
      if (c == 3) begin
        total++;
        if (b1.fetch_data_out !== 32'hDEADBEEF) begin
          bad++;
          $display("FAIL fetch_data got=%h expected deadbeef", b1.fetch_data_out);
        end
      end
      next_cycle();
    end
    b1.fetch_req_in = 1'b0;
    next_cycle();
  endtask

  task automatic test_ldr_write();
    int we_cycles;
    we_cycles = 0;
    b1.ldr_req_in = 1'b1; b1.ldr_we_in = 1'b1; b1.ldr_addr_in = 20'h00100;
    b1.ldr_wdata_in = 32'h12345678; b1.mem_data_in = 32'h0BADF00D;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) begin
        b1.ldr_req_in = 1'b0; b1.ldr_we_in = 1'b0;
      end
      @(negedge clk);
      if (b1.mem_we_out === 1'b1) we_cycles++;
      total++;
      if (b1.ldr_gnt_out !== (c == 3) || b1.fetch_gnt_out !== 1'b0) begin
        bad++;
        $display("FAIL ldr_gnt cyc=%0d lgnt=%b fgnt=%b expected %b 0", c, b1.ldr_gnt_out, b1.fetch_gnt_out, (c == 3));
      end
      if (c == 1) begin
        total++;
        if (b1.mem_wdata_out !== 32'h12345678 || b1.mem_addr_out !== 20'h00100 || b1.mem_cs_out !== 1'b1) begin
          bad++;
          $display("FAIL ldr_wr_bus wdata=%h addr=%h cs=%b expected 12345678 00100 1",
                   b1.mem_wdata_out, b1.mem_addr_out, b1.mem_cs_out);
        end
      end
      if (c == 3) begin
        total++;
        if (b1.fetch_data_out !== 32'hDEADBEEF || b1.ldr_rdata_out !== 32'hA5A5A5A5) begin
          bad++;
          $display("FAIL ldr_wr_hold fdata=%h lrdata=%h expected deadbeef a5a5a5a5",
                   b1.fetch_data_out, b1.ldr_rdata_out);
        end
      end
      next_cycle();
    end
    total++;
    if (we_cycles != 2) begin
      bad++;
      $display("FAIL ldr_we_len got=%0d expected 2", we_cycles);
    end
  endtask

  task automatic test_contention();
    logic [9:0] exp_ldr;
    logic [9:0] got_ldr;
    int n;
    exp_ldr = 10'b0111101111;  // bit i: grant i went to loader (LLLLFLLLLF)
    got_ldr = '0;
    n = 0;
    b1.fetch_req_in = 1'b1; b1.fetch_addr_in = 20'h00020;
    b1.ldr_req_in = 1'b1; b1.ldr_we_in = 1'b0; b1.ldr_addr_in = 20'h00030;
    for (int c = 0; c < 80 && n < 10; c++) begin
      @(negedge clk);
      if (b1.fetch_gnt_out === 1'b1 && b1.ldr_gnt_out === 1'b1) begin
        total++; bad++;
        $display("FAIL contention_dual cyc=%0d both gnt high, expected one", c);
      end
      if (b1.fetch_gnt_out === 1'b1 || b1.ldr_gnt_out === 1'b1) begin
        got_ldr[n] = b1.ldr_gnt_out;
        n++;
      end
      next_cycle();
    end
    b1.fetch_req_in = 1'b0; b1.ldr_req_in = 1'b0;
    total++;
    if (n != 10) begin
      bad++;
      $display("FAIL contention_timeout grants=%0d expected 10", n);
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (got_ldr[i] !== exp_ldr[i]) begin
        bad++;
        $display("FAIL contention_order idx=%0d ldr=%b expected %b", i, got_ldr[i], exp_ldr[i]);
      end
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid_access();
    b3.fetch_req_in = 1'b1; b3.fetch_addr_in = 20'h00ABC; b3.mem_data_in = 32'hCAFEF00D;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rst = 1'b1;
      @(negedge clk);
      total++;
      if (b3.mem_cs_out !== (c == 1) || b3.fetch_gnt_out !== 1'b0) begin
        bad++;
        $display("FAIL mid_rst_cs cyc=%0d cs=%b gnt=%b expected %b 0", c, b3.mem_cs_out, b3.fetch_gnt_out, (c == 1));
      end
      if (c == 3) begin
        total++;
        if (b3.fetch_data_out !== 32'h0 || b3.mem_we_out !== 1'b0) begin
          bad++;
          $display("FAIL mid_rst_data fdata=%h we=%b expected 0 0", b3.fetch_data_out, b3.mem_we_out);
        end
      end
      next_cycle();
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (b3.mem_cs_out !== (c >= 1 && c <= 4) || b3.fetch_gnt_out !== (c == 5)) begin
        bad++;
        $display("FAIL rerun_seq cyc=%0d cs=%b gnt=%b expected %b %b", c,
                 b3.mem_cs_out, b3.fetch_gnt_out, (c >= 1 && c <= 4), (c == 5));
      end
      if (c == 1) begin
        total++;
        if (b3.mem_addr_out !== 20'h00ABC) begin
          bad++;
          $display("FAIL rerun_addr got=%h expected 00abc", b3.mem_addr_out);
        end
      end
      if (c == 5) begin
        total++;
        if (b3.fetch_data_out !== 32'hCAFEF00D) begin
          bad++;
          $display("FAIL rerun_data got=%h expected cafef00d", b3.fetch_data_out);
        end
      end
      next_cycle();
    end
    b3.fetch_req_in = 1'b0;
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_addr;
    logic [31:0] exp_data;
    b0.fetch_req_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c % 3 == 0) begin
        b0.fetch_addr_in = 20'h00200 + 20'(c / 3);
        b0.mem_data_in   = 32'h00001000 + 32'(c / 3);
      end
      exp_addr = 20'h00200 + 20'(c / 3);
      exp_data = 32'h00001000 + 32'(c / 3);
      @(negedge clk);
      total++;
      if (b0.mem_cs_out !== (c % 3 == 1) || b0.fetch_gnt_out !== (c % 3 == 2) || b0.fetch_stall_out !== (c % 3 != 2)) begin
        bad++;
        $display("FAIL b2b_seq cyc=%0d cs=%b gnt=%b stall=%b expected %b %b %b", c,
                 b0.mem_cs_out, b0.fetch_gnt_out, b0.fetch_stall_out, (c % 3 == 1), (c % 3 == 2), (c % 3 != 2));
      end
      if (c % 3 == 1) begin
        total++;
        if (b0.mem_addr_out !== exp_addr) begin
          bad++;
          $display("FAIL b2b_addr cyc=%0d got=%h expected %h", c, b0.mem_addr_out, exp_addr);
        end
      end
      if (c % 3 == 2) begin
        total++;
        if (b0.fetch_data_out !== exp_data) begin
          bad++;
          $display("FAIL b2b_data cyc=%0d got=%h expected %h", c, b0.fetch_data_out, exp_data);
        end
      end
      next_cycle();
    end
    b0.fetch_req_in = 1'b0;
    next_cycle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    b1.fetch_req_in = 1'b0; b1.fetch_addr_in = '0; b1.ldr_req_in = 1'b0; b1.ldr_we_in = 1'b0;
    b1.ldr_addr_in = '0; b1.ldr_wdata_in = '0; b1.mem_data_in = '0;
    b3.fetch_req_in = 1'b0; b3.fetch_addr_in = '0; b3.ldr_req_in = 1'b0; b3.ldr_we_in = 1'b0;
    b3.ldr_addr_in = '0; b3.ldr_wdata_in = '0; b3.mem_data_in = '0;
    b0.fetch_req_in = 1'b0; b0.fetch_addr_in = '0; b0.ldr_req_in = 1'b0; b0.ldr_we_in = 1'b0;
    b0.ldr_addr_in = '0; b0.ldr_wdata_in = '0; b0.mem_data_in = '0;
    test_reset();
    test_fetch_read();
    test_ldr_write();
    test_contention();
    test_reset_mid_access();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Sequences the single-port instruction SRAM and shares it between two requesters: the fetch stage (PC-driven reads) and the program loader/debug port (reads and writes).
- Inserts a configurable number of SRAM wait states and drives a stall to the fetch stage until its instruction word is valid.
- Sits between the fetch stage, the loader, and the instruction SRAM pins.

Parameters:
ADDR_WIDTH, 20, instruction address width (matches PC width)
DATA_WIDTH, 32, instruction/SRAM data width
MEM_WAIT_STATES, 1, extra SRAM cycles before read data is valid; legal range 0..15
LDR_MAX_BURST, 4, max consecutive loader grants while fetch is pending; legal range 1..15

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-high (reset while rst_n=1)
fetch_req_in  in  1  fetch requests a read; held until fetch_gnt_out
fetch_addr_in  in  ADDR_WIDTH  fetch read address
fetch_gnt_out  out  1  one-cycle pulse; fetch_data_out valid
fetch_data_out  out  DATA_WIDTH  fetched word (registered)
fetch_stall_out  out  1  fetch must hold the PC
ldr_req_in  in  1  loader request; held until ldr_gnt_out
ldr_we_in  in  1  1=write, 0=read
ldr_addr_in  in  ADDR_WIDTH  loader address
ldr_wdata_in  in  DATA_WIDTH  loader write data
ldr_gnt_out  out  1  one-cycle pulse; access complete
ldr_rdata_out  out  DATA_WIDTH  loader read data (registered)
mem_cs_out  out  1  SRAM chip select
mem_we_out  out  1  SRAM write enable
mem_addr_out  out  ADDR_WIDTH  SRAM address
mem_wdata_out  out  DATA_WIDTH  SRAM write data
mem_data_in  in  DATA_WIDTH  SRAM read data

Behaviour:
- Reset: all outputs 0 except fetch_stall_out, which follows its equation. State IDLE; wait counter, starvation counter and owner all 0.
- FSM states:
  - IDLE: if any request is pending, select a winner; register mem_cs=1, mem_we (loader writes only), mem_addr and mem_wdata from the winner; load wait counter with MEM_WAIT_STATES; go to ACCESS. If no request, stay in IDLE with mem_cs=0.
  - ACCESS: mem_* outputs are held constant. Counter decrements each cycle while nonzero. In the cycle the counter is 0:
    - capture mem_data_in into the owner's data register (reads only);
    - register the owner's gnt=1, mem_cs=0, mem_we=0;
    - go to RESP.
  - RESP: gnt is high for exactly this cycle; return to IDLE. Requester inputs are ignored in RESP.
- Latency:
  - Request first seen in IDLE at cycle T.
  - mem_cs is high for cycles T+1 .. T+1+MEM_WAIT_STATES.
  - gnt is high at cycle T+2+MEM_WAIT_STATES.
  - Earliest next arbitration is cycle T+3+MEM_WAIT_STATES.
- Address and data are latched at grant; input changes during ACCESS are ignored.
- Arbitration: the loader has fixed priority, with a starvation guard.
  - The starvation counter increments on each loader grant made while fetch_req_in=1.
  - When the counter equals LDR_MAX_BURST and fetch is pending, fetch wins.
  - The counter clears on any fetch grant, and in any IDLE cycle with fetch_req_in=0.
- fetch_stall_out = fetch_req_in AND NOT fetch_gnt_out (combinational).
- Data registers hold their last value until the next read completion for the same owner. A loader write does not modify ldr_rdata_out.
- Reset asserted mid-ACCESS or mid-RESP: immediately return to IDLE, drop mem_cs/mem_we, clear gnt. No completion is issued; requesters re-arbitrate after reset is released.
- A requester dropping its request during ACCESS is a protocol violation. The access still completes and gnt still pulses.
- MEM_WAIT_STATES=0 is legal: ACCESS lasts exactly one cycle.

Decomposition:
- Shared package udlx_imem_pkg holds:
  - state encoding IMEM_IDLE/IMEM_ACCESS/IMEM_RESP;
  - owner encoding OWNER_FETCH=0, OWNER_LDR=1;
  - the counter width constant, clog2(MEM_WAIT_STATES+1) with a minimum of 1.
- One sub-module, imem_wait_counter: loadable down-counter with a zero flag, async active-high reset.

Test Plan:
1. Reset: hold rst_n=1 for 3 cycles with both requests high -> all mem_* and gnt outputs 0, no SRAM access; first access starts after rst_n=0.
2. Single fetch read, MEM_WAIT_STATES=1: fetch_req at T0, addr 0x00010, mem_data_in=0xDEADBEEF -> mem_cs high T1–T2 with mem_addr=0x00010; fetch_gnt at T3 with data 0xDEADBEEF; stall high T0–T2, low T3.
3. Loader write, MEM_WAIT_STATES=1: we=1, addr 0x00100, wdata 0x12345678 -> mem_we high exactly 2 cycles, mem_wdata=0x12345678; ldr_gnt pulse at T3; fetch_data_out unchanged.
4. Contention, LDR_MAX_BURST=4: both requesters held high continuously -> grant order L,L,L,L,F,L,L,L,L,F.
5. Reset mid-ACCESS with MEM_WAIT_STATES=3: assert rst_n during the second ACCESS cycle -> mem_cs=0 at once and no gnt. After release, the same request completes with full latency.
6. MEM_WAIT_STATES=0, fetch requests back-to-back -> fetch_gnt every 3 cycles, mem_cs high 1 of every 3 cycles.
